// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and helpers for the front-end stall/flush sequencer.
// Holds the FSM state encoding, default stage indices and the prefix-mask helper.
package pipeline_ctrl_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MC_WAIT = 1'b1
   } ctrl_state_t;

   localparam int DEF_NUM_STAGES = 5;
   localparam int DEF_DEC_STAGE  = 1;
   localparam int DEF_EX_STAGE   = 2;
   localparam int DEF_CNT_W      = 4;
   localparam int DEF_PERF_W     = 32;
   localparam int MASK_W         = 32;

   // Bits 0..k-1 set; callers size-cast the result down to their buffer count.
   function automatic logic [MASK_W-1:0] mask_below(input int k);
      logic [MASK_W-1:0] m;
      m = '0;
      for (int i = 0; i < MASK_W; i++) begin
         if (i < k) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_stall_cycle_counter.sv
// Loadable down-counter tracking the remaining hold cycles of a multi-cycle EX op.
// done flags the last hold cycle (count==1).
module stall_cycle_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   input  logic         clear,
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign done = (count == W'(1));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the front-end buffer chain: merges redirects, back-pressure,
// multi-cycle EX waits and load-use hazards into per-buffer stall and bubble vectors.
module pipeline_hazard_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int NUM_STAGES = DEF_NUM_STAGES,
   parameter int DEC_STAGE  = DEF_DEC_STAGE,
   parameter int EX_STAGE   = DEF_EX_STAGE,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int PERF_W     = DEF_PERF_W
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          load_use_haz,
   input  logic                          mc_start,
   input  logic [CNT_W-1:0]              mc_cycles,
   input  logic                          backend_full,
   input  logic                          flush_req,
   input  logic [$clog2(NUM_STAGES)-1:0] flush_stage,
   output logic [NUM_STAGES-1:0]         stall,
   output logic [NUM_STAGES-1:0]         flush,
   output logic                          mc_busy,
   output logic [PERF_W-1:0]             stall_cycles
);

   localparam logic [NUM_STAGES-1:0] EX_HOLD    = NUM_STAGES'(mask_below(EX_STAGE + 1));
   localparam logic [NUM_STAGES-1:0] DEC_HOLD   = NUM_STAGES'(mask_below(DEC_STAGE + 1));
   localparam logic [NUM_STAGES-1:0] EX_BUBBLE  = NUM_STAGES'(1) << (EX_STAGE + 1);
   localparam logic [NUM_STAGES-1:0] DEC_BUBBLE = NUM_STAGES'(1) << (DEC_STAGE + 1);

   ctrl_state_t             state;
   ctrl_state_t             next_state;
   logic                    in_wait;
   logic                    mc_kill;
   logic [NUM_STAGES-1:0]   fs_mask;
   logic                    cnt_load;
   logic                    cnt_dec;
   logic                    cnt_clear;
   logic                    cnt_done;

   assign in_wait = (state == MC_WAIT);
   assign mc_kill = flush_req && (int'(flush_stage) > EX_STAGE);
   assign fs_mask = NUM_STAGES'(mask_below(int'(flush_stage)));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= next_state;
      end
   end

   // Priority mux: redirect > back-pressure > multi-cycle wait > load-use.
   always_comb begin
      stall   = '0;
      flush   = '0;
      mc_busy = in_wait;
      if (reset) begin
         flush   = '1;
         mc_busy = 1'b0;
      end else if (flush_req) begin
         flush = fs_mask;
         if (in_wait && !mc_kill) stall = EX_HOLD & ~fs_mask;
      end else if (backend_full) begin
         stall = '1;
      end else if (in_wait) begin
         stall = EX_HOLD;
         flush = EX_BUBBLE;
      end else if (load_use_haz) begin
         stall = DEC_HOLD;
         flush = DEC_BUBBLE;
      end
   end

   // The EX unit keeps counting through back-pressure and surviving redirects.
   always_comb begin
      next_state = state;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      cnt_clear  = 1'b0;
      case (state)
         RUN: begin
            if (mc_start && !stall[EX_STAGE] && (mc_cycles >= CNT_W'(2))) begin
               next_state = MC_WAIT;
               cnt_load   = 1'b1;
            end
         end
         MC_WAIT: begin
            if (mc_kill) begin
               next_state = RUN;
               cnt_clear  = 1'b1;
            end else begin
               cnt_dec = 1'b1;
               if (cnt_done) next_state = RUN;
            end
         end
         default: next_state = RUN;
      endcase
   end

   stall_cycle_counter #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (mc_cycles - CNT_W'(1)),
      .dec      (cnt_dec),
      .clear    (cnt_clear),
      .done     (cnt_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (stall[0] && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + PERF_W'(1);
      end
   end

endmodule
